mips_bus_arbiter: RTL and testbench

Two-master, one-slave Avalon-MM arbiter that shares the single memory bus between the multicycle CPU (master 0) and a debug/program-loader port (master 1). It grants the bus to one requester per transfer, passes the transfer through combinationally, and returns each master's waitrequest so the CPU state machine stalls correctly. A watchdog aborts transfers the slave never completes.

---
 rtl/mips_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave Avalon-MM bus arbiter with a transfer watchdog.
// Define ARB_ROUND_ROBIN_EN to alternate winners on contention; otherwise m0 has fixed priority.
module mips_bus_arbiter #(
   parameter int unsigned TIMEOUT  = 256,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   output logic [1:0]  grant,
   output logic        bus_error
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam bit WD_EN = (TIMEOUT > 0);

   state_t           state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic             req0, req1, own_req, completing, abort, pick_m0;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;   // 1 means m1 was the last master to complete
`endif

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_comb begin
      own_req = 1'b0;
      case (state)
         OWN0:    own_req = req0;
         OWN1:    own_req = req1;
         default: own_req = 1'b0;
      endcase
   end

   // Completion has priority over the watchdog when both land on the same cycle.
   assign completing = own_req & ~s_waitrequest;
   assign abort      = WD_EN & own_req & s_waitrequest & (count == WD_LAST);

`ifdef ARB_ROUND_ROBIN_EN
   assign pick_m0 = last_grant;
`else
   assign pick_m0 = 1'b1;
`endif

   assign grant          = {state == OWN1, state == OWN0};
   assign m0_waitrequest = req0 & ~((state == OWN0) & (completing | abort));
   assign m1_waitrequest = req1 & ~((state == OWN1) & (completing | abort));

   // Slave side mirrors the owner; a read+write request is carried out as a write.
   always_comb begin
      s_address    = '0;
      s_read       = 1'b0;
      s_write      = 1'b0;
      s_writedata  = '0;
      s_byteenable = '0;
      m0_readdata  = '0;
      m1_readdata  = '0;
      case (state)
         OWN0: begin
            s_address    = m0_address;
            s_writedata  = m0_writedata;
            s_byteenable = m0_byteenable;
            s_write      = m0_write & ~abort;
            s_read       = m0_read & ~m0_write & ~abort;
            m0_readdata  = abort ? ERR_DATA : s_readdata;
         end
         OWN1: begin
            s_address    = m1_address;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
            s_write      = m1_write & ~abort;
            s_read       = m1_read & ~m1_write & ~abort;
            m1_readdata  = abort ? ERR_DATA : s_readdata;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_next = state;
      count_next = '0;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || pick_m0)) begin
               state_next = OWN0;
            end else if (req1) begin
               state_next = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (!own_req || completing || abort) begin
               state_next = IDLE;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         bus_error <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant <= 1'b1;
`endif
      end else begin
         state     <= state_next;
         count     <= count_next;
         bus_error <= abort;
`ifdef ARB_ROUND_ROBIN_EN
         if (completing) begin
            last_grant <= (state == OWN1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transfer-level reference model.
module tb_mips_bus_arbiter;

   localparam int          TO  = 8;
   localparam logic [31:0] ERR = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, m0_readdata, m1_readdata;
   logic        m0_read, m1_read, m0_write, m1_write, m0_waitrequest, m1_waitrequest;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic [31:0] s_address, s_writedata, s_readdata;
   logic        s_read, s_write, s_waitrequest, bus_error;
   logic [1:0]  grant;

   // stimulus state per master
   logic        rd [2];
   logic        wr [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [3:0]  be [2];
   logic        s_wait;
   logic [31:0] s_rdata;

   // reference model: owner index (-1 none), owned wait cycles, last completer
   int  owner, cnt, last;
   bit  err_pend, e_done, e_abort;
   bit  served [2];
   int  checks, errors;

   always #5 clk = ~clk;

   mips_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .grant(grant), .bus_error(bus_error)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus();
      m0_read = rd[0];  m0_write = wr[0];  m0_address = addr[0];
      m0_writedata = wdata[0];  m0_byteenable = be[0];
      m1_read = rd[1];  m1_write = wr[1];  m1_address = addr[1];
      m1_writedata = wdata[1];  m1_byteenable = be[1];
      s_waitrequest = s_wait;  s_readdata = s_rdata;
   endtask

   task automatic model_reset();
      owner = -1; cnt = 0; last = 1; err_pend = 1'b0;
   endtask

   // Check every output against the model, then advance the model across the clock edge.
   task automatic run_cycle();
      bit          req [2];
      bit          ow_req, both;
      logic [31:0] exp_grant, exp_wait, exp_rd;
      int          win;
      #1;
      if (!reset) model_reset();
      req[0] = rd[0] | wr[0];
      req[1] = rd[1] | wr[1];
      ow_req  = (owner >= 0) && req[owner];
      e_done  = ow_req && !s_wait;
      e_abort = ow_req && s_wait && (TO > 0) && (cnt == TO - 1);
      exp_grant = (owner == 0) ? 32'd1 : (owner == 1) ? 32'd2 : 32'd0;
      checkOutput("grant", 32'(grant), exp_grant);
      checkOutput("bus_error", 32'(bus_error), 32'(err_pend));
      for (int x = 0; x < 2; x++) begin
         exp_wait = 32'(req[x] && !((owner == x) && (e_done || e_abort)));
         exp_rd   = (owner == x) ? (e_abort ? ERR : s_rdata) : 32'd0;
         served[x] = req[x] && (exp_wait == 0);
         checkOutput(x == 0 ? "m0_waitrequest" : "m1_waitrequest",
                     32'(x == 0 ? m0_waitrequest : m1_waitrequest), exp_wait);
         checkOutput(x == 0 ? "m0_readdata" : "m1_readdata",
                     x == 0 ? m0_readdata : m1_readdata, exp_rd);
      end
      if (owner >= 0) begin
         checkOutput("s_read", 32'(s_read), 32'(rd[owner] && !wr[owner] && !e_abort));
         checkOutput("s_write", 32'(s_write), 32'(wr[owner] && !e_abort));
         checkOutput("s_address", s_address, addr[owner]);
         checkOutput("s_writedata", s_writedata, wdata[owner]);
         checkOutput("s_byteenable", 32'(s_byteenable), 32'(be[owner]));
      end else begin
         checkOutput("s_idle_strobes", {30'd0, s_read, s_write}, 32'd0);
         checkOutput("s_idle_bus", s_address | s_writedata | 32'(s_byteenable), 32'd0);
      end
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         err_pend = e_abort;
         if (owner < 0) begin
            both = req[0] && req[1];
`ifdef ARB_ROUND_ROBIN_EN
            win = both ? ((last == 1) ? 0 : 1) : (req[0] ? 0 : (req[1] ? 1 : -1));
`else
            win = req[0] ? 0 : (req[1] ? 1 : -1);
`endif
            owner = win;
            cnt = 0;
         end else if (!ow_req || e_abort) begin
            owner = -1; cnt = 0;
         end else if (e_done) begin
            last = owner; owner = -1; cnt = 0;
         end else begin
            cnt++;
         end
      end
      #1;
   endtask

   task automatic clear_masters();
      for (int x = 0; x < 2; x++) begin
         rd[x] = 1'b0; wr[x] = 1'b0; addr[x] = '0; wdata[x] = '0; be[x] = '0;
      end
   endtask

   initial begin
      int stuck_left;
      checks = 0; errors = 0;
      reset = 1'b0;
      clear_masters();
      s_wait = 1'b0; s_rdata = '0;
      model_reset();
      applyStimulus();
      run_cycle();
      run_cycle();
      reset = 1'b1;

      // m0 read with zero-wait slave
      rd[0] = 1'b1; addr[0] = 32'hBFC0_0000; s_rdata = 32'h1234_5678;
      applyStimulus(); #1;
      checkOutput("rd_bubble_grant", 32'(grant), 32'd0);
      checkOutput("rd_bubble_wait", 32'(m0_waitrequest), 32'd1);
      run_cycle();
      applyStimulus(); #1;
      checkOutput("rd_grant", 32'(grant), 32'd1);
      checkOutput("rd_data", m0_readdata, 32'h1234_5678);
      checkOutput("rd_wait", 32'(m0_waitrequest), 32'd0);
      run_cycle();
      rd[0] = 1'b0; applyStimulus(); run_cycle();

      // contention: m1 always re-requests, m0 only for the first few cycles
      rd[0] = 1'b1; rd[1] = 1'b1; addr[0] = 32'h100; addr[1] = 32'h200;
      for (int c = 0; c < 12; c++) begin
         s_rdata = $urandom;
         applyStimulus();
         if (c == 1) begin
            #1;
            checkOutput("contend_first", 32'(grant), 32'd1);
         end
         run_cycle();
         if (served[0]) begin rd[0] = (c < 4); addr[0] += 4; end
         if (served[1]) addr[1] += 4;
      end
      clear_masters(); applyStimulus(); run_cycle(); run_cycle();

      // m1 write with three slave wait cycles
      wr[1] = 1'b1; addr[1] = 32'h1000; wdata[1] = 32'hCAFE_F00D; be[1] = 4'b0011; s_wait = 1'b1;
      applyStimulus(); run_cycle();
      for (int k = 0; k < 4; k++) begin
         s_wait = (k < 3);
         applyStimulus(); #1;
         checkOutput("wr_strobe", 32'(s_write), 32'd1);
         checkOutput("wr_data", s_writedata, 32'hCAFE_F00D);
         checkOutput("wr_be", 32'(s_byteenable), 32'h3);
         checkOutput("wr_wait", 32'(m1_waitrequest), 32'(k < 3));
         run_cycle();
      end
      clear_masters(); applyStimulus(); run_cycle();

      // watchdog: slave never releases waitrequest
      rd[0] = 1'b1; addr[0] = 32'hA0; s_wait = 1'b1;
      applyStimulus(); run_cycle();
      for (int k = 0; k < TO; k++) begin
         applyStimulus();
         if (k == TO - 1) begin
            #1;
            checkOutput("wd_data", m0_readdata, ERR);
            checkOutput("wd_wait", 32'(m0_waitrequest), 32'd0);
            checkOutput("wd_sread", 32'(s_read), 32'd0);
         end
         run_cycle();
      end
      rd[0] = 1'b0; rd[1] = 1'b1; addr[1] = 32'hB0; s_wait = 1'b0;
      applyStimulus(); #1;
      checkOutput("wd_bus_error", 32'(bus_error), 32'd1);
      run_cycle();
      applyStimulus(); #1;
      checkOutput("wd_next_grant", 32'(grant), 32'd2);
      checkOutput("wd_next_wait", 32'(m1_waitrequest), 32'd0);
      run_cycle();
      clear_masters(); applyStimulus(); run_cycle();

      // reset in the middle of a stalled m0 read
      rd[0] = 1'b1; addr[0] = 32'hC0; s_wait = 1'b1;
      applyStimulus(); run_cycle(); run_cycle();
      reset = 1'b0; #1;
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_strobes", {30'd0, s_read, s_write}, 32'd0);
      run_cycle(); run_cycle();
      reset = 1'b1; s_wait = 1'b0;
      applyStimulus(); run_cycle();
      applyStimulus(); #1;
      checkOutput("rst_regrant", 32'(grant), 32'd1);
      checkOutput("rst_complete", 32'(m0_waitrequest), 32'd0);
      run_cycle();
      clear_masters(); applyStimulus(); run_cycle();

      // simultaneous read and write is executed as a write
      rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'hD0; wdata[0] = 32'h5555_AAAA; be[0] = 4'hF;
      applyStimulus(); run_cycle();
      applyStimulus(); #1;
      checkOutput("rw_write", 32'(s_write), 32'd1);
      checkOutput("rw_read", 32'(s_read), 32'd0);
      run_cycle();
      clear_masters(); applyStimulus(); run_cycle();

      // randomized traffic
      stuck_left = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int x = 0; x < 2; x++) begin
            if (!(rd[x] || wr[x]) || served[x] || ($urandom_range(0, 31) == 0)) begin
               int kind;
               kind = $urandom_range(0, 14);
               rd[x] = (kind < 5) || (kind == 9);
               wr[x] = (kind >= 5) && (kind <= 9);
               addr[x] = $urandom; wdata[x] = $urandom; be[x] = 4'($urandom);
            end
         end
         if (stuck_left > 0) begin
            s_wait = 1'b1; stuck_left--;
         end else if ($urandom_range(0, 63) == 0) begin
            s_wait = 1'b1; stuck_left = 12;
         end else begin
            s_wait = ($urandom_range(0, 2) == 0);
         end
         s_rdata = $urandom;
         reset = ($urandom_range(0, 499) != 0);
         applyStimulus();
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
